async_fifo_wr_arbiter: RTL and testbench
========================================

# async_fifo_wr_arbiter

Packet-aware round-robin arbiter that shares the write port of one `async_fifo` among N requesters in the write-clock domain. It grants one requester at a time, holds the grant until that requester's `last` beat is written, and never asserts a write while the FIFO reports full. Each FIFO word carries `{last, data}`, so the read side can recover packet boundaries.

## Interface
- `N`, default 4: number of requesters; legal range 2..16.
- `W`, default 32: data width per requester. The FIFO word width is `W+1`.

- `clk`, in, 1: clock. Connected to the FIFO `wr_clk`.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, N: per-requester beat valid.
- `req_last`, in, N: per-requester end-of-packet flag, qualified by valid.
- `req_data`, in, N*W: per-requester data; requester i occupies bits `[i*W +: W]`.
- `req_ready`, out, N: per-requester beat accepted; one-hot or zero.
- `fifo_wr_full`, in, 1: FIFO `wr_full`.
- `fifo_wr_en`, out, 1: FIFO `wr_en`.
- `fifo_wr_data`, out, W+1: FIFO `wr_data` = `{last, data}` of the granted requester.
- `grant_id`, out, `$clog2(N)`: index of the current or most recent grant.
- `busy`, out, 1: a packet grant is active.

## Operation
- The state machine has two states, IDLE and GRANT.
- **IDLE**
  - If any `req_valid` is high, select the first valid requester scanning upward, modulo N, from `rr_ptr`.
  - Register the selection into `grant_id`, set `busy`, and go to GRANT.
  - If no request is valid, stay in IDLE.
  - No beat is accepted while in IDLE.
- **GRANT**
  - `req_ready[grant_id] = ~fifo_wr_full`. All other ready bits are 0.
  - A beat transfers when `req_valid[grant_id] & req_ready[grant_id]`.
  - `fifo_wr_en` = beat transfer. `fifo_wr_data = {req_last[g], req_data[g]}`.
  - If a transferred beat has `req_last` = 1: go to IDLE next cycle, clear `busy`, set `rr_ptr = grant_id+1` (wrapping from N-1 to 0).
  - If the granted requester drops valid mid-packet, the grant is held. Other requesters are not served until its `last` beat.
- **Invariant:** `fifo_wr_en & fifo_wr_full` is never 1. The bench flags a violation as an error.
- `req_ready`, `fifo_wr_en` and `fifo_wr_data` are combinational from the registered state, `fifo_wr_full` and the granted requester's inputs. No combinational path exists from non-granted requesters to outputs.
- A requester that drops valid before being granted simply loses the arbitration. No state is kept for it.

## Timing
- Reset values: state IDLE, `busy` 0, `grant_id` 0, `rr_ptr` 0 (requester 0 has first priority), `req_ready` 0, `fifo_wr_en` 0.
  - `fifo_wr_data` is don't-care when `fifo_wr_en` is 0; it is driven from requester 0's inputs.
- Arbitration latency: a valid request seen in IDLE at cycle t gets `req_ready` at cycle t+1, given the FIFO is not full.
- Throughput:
  - Within a packet: one beat per cycle while valid and not full.
  - Between packets: exactly one idle cycle, the IDLE arbitration cycle.
- Packet of length L with no backpressure occupies L+1 cycles from IDLE to IDLE.
- Full mid-packet: ready and write drop in the same cycle that `fifo_wr_full` is high, and resume the cycle it falls. The grant is held.
- Simultaneous requests: serviced in round-robin order starting at `rr_ptr`. No requester waits more than N-1 packets.
- Reset asserted mid-packet:
  - All outputs go to reset values immediately (asynchronous).
  - The partial packet in the FIFO is not retracted; the FIFO must be reset alongside.
  - After deassertion, arbitration restarts at requester 0.
- `req_last` on a non-transferred cycle has no effect.

## Test plan
- Single packet: requester 2 sends 3 beats (data 0xA0, 0xA1, 0xA2; last on the third), FIFO never full.
  - Required: `busy` rises 1 cycle after valid.
  - FIFO receives {0,A0}, {0,A1}, {1,A2} on consecutive cycles.
  - `rr_ptr` becomes 3.
  - Back to IDLE 4 cycles after the request.
- All 4 requesters hold valid with single-beat packets.
  - Required: write order 0,1,2,3,0,1…, one write every 2 cycles.
- Requesters 1 and 3 each send 2-beat packets, and requester 3 asserts valid first.
  - Required: 3's packet completes unbroken, then 1's.
  - No interleaving of the two packets in FIFO words.
- `fifo_wr_full` held high for 5 cycles mid-packet, with the granted requester still valid.
  - Required: `req_ready` and `fifo_wr_en` stay 0 during those cycles.
  - `grant_id` is unchanged, and no beat is lost or duplicated.
- Granted requester drops valid for 3 cycles mid-packet while others are valid.
  - Required: the grant is held and no other requester is written.
  - The packet resumes when valid returns.
- `reset` pulsed after beat 2 of a 4-beat packet from requester 1.
  - Required: `busy`, `req_ready` and `fifo_wr_en` go to 0 asynchronously.
  - After release, requester 0 wins if 0 and 1 are both valid.

Source files
------------

// File: rtl/async_fifo_wr_arbiter_if.sv
// Requester/FIFO write-port bundle for the packet arbiter; master drives requests and FIFO status,
// slave (the arbiter) returns per-requester ready, the FIFO write strobe/word and grant status.
interface async_fifo_wr_arbiter_if #(
    parameter int N = 4,
    parameter int W = 32
);
    localparam int GW = $clog2(N);

    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_wr_full;
    logic           fifo_wr_en;
    logic [W:0]     fifo_wr_data;
    logic [GW-1:0]  grant_id;
    logic           busy;

    modport master (
        output req_valid, req_last, req_data, fifo_wr_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_wr_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );
endinterface

// File: rtl/async_fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter for one FIFO write port; grant 1 cycle after request, then 1 beat/cycle.
// Backpressure: ready/write follow ~fifo_wr_full combinationally; the grant is held until the last beat.
module async_fifo_wr_arbiter #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    async_fifo_wr_arbiter_if.slave bus
);
    localparam int GW = $clog2(N);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] sel_idx;
    logic          sel_vld;
    logic          g_valid;
    logic          g_last;
    logic [W-1:0]  g_data;

    // Only the granted requester reaches the outputs; the scan below feeds next-state only.
    assign g_valid = bus.req_valid[grant_q];
    assign g_last  = bus.req_last[grant_q];
    assign g_data  = bus.req_data[int'(grant_q) * W +: W];

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = rr_ptr_q;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!sel_vld && bus.req_valid[idx]) begin
                sel_vld = 1'b1;
                sel_idx = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        bus.req_ready  = '0;
        bus.fifo_wr_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    grant_d = sel_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                bus.req_ready[grant_q] = ~bus.fifo_wr_full;
                bus.fifo_wr_en         = g_valid & ~bus.fifo_wr_full;
                if (g_valid && !bus.fifo_wr_full && g_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == GW'(N - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.fifo_wr_data = {g_last, g_data};
    assign bus.grant_id     = grant_q;
    assign bus.busy         = (state_q == GRANT);
endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed bench for async_fifo_wr_arbiter: per-requester packet sources, FIFO word capture
// and hand-computed expected grants/words for each scenario.
module tb_async_fifo_wr_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    async_fifo_wr_arbiter_if #(.N(N), .W(W)) bus ();

    async_fifo_wr_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         plen  [N];
    int         total [N];
    int         cnt   [N];
    logic [W-1:0] base [N];
    logic       en    [N];
    logic [W:0] wq[$];
    logic [1:0] rr_order [8] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Words are captured mid-cycle, while inputs are stable ahead of the writing edge.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert (!(bus.fifo_wr_en && bus.fifo_wr_full)) else begin
                errors++;
                $error("FAIL wr_while_full: observed wr_en=%0b full=%0b expected no write", bus.fifo_wr_en, bus.fifo_wr_full);
            end
        end
        if (bus.fifo_wr_en) wq.push_back(bus.fifo_wr_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input string tag, input logic [W:0] exp);
        logic [W:0] got;
        if (wq.size() == 0) got = 'x;
        else got = wq.pop_front();
        check(tag, {31'b0, got}, {31'b0, exp});
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            logic v;
            v = en[i] && (cnt[i] < total[i]);
            bus.req_valid[i]       = v;
            bus.req_last[i]        = v && ((cnt[i] % plen[i]) == plen[i] - 1);
            bus.req_data[i*W +: W] = v ? base[i] + W'(cnt[i]) : '0;
        end
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    task automatic start(input int i, input int pl, input int np, input logic [W-1:0] b);
        plen[i]  = pl;
        total[i] = pl * np;
        cnt[i]   = 0;
        base[i]  = b;
        en[i]    = 1'b1;
    endtask

    task automatic tick();
        logic [N-1:0] x;
        x = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (x[i]) cnt[i]++;
        drive();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.fifo_wr_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            plen[i] = 1; total[i] = 0; cnt[i] = 0; base[i] = '0; en[i] = 1'b1;
        end
        drive();
        #2;
        check("rst_busy",   bus.busy, 0);
        check("rst_grant",  bus.grant_id, 0);
        check("rst_ready",  bus.req_ready, 0);
        check("rst_wr_en",  bus.fifo_wr_en, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // Single 3-beat packet from requester 2.
        start(2, 3, 1, 32'hA0);
        settle();
        check("t1_idle_busy",  bus.busy, 0);
        check("t1_idle_ready", bus.req_ready, 0);
        tick();
        check("t1_busy",  bus.busy, 1);
        check("t1_grant", bus.grant_id, 2);
        check("t1_ready", bus.req_ready, 4'b0100);
        check("t1_wr0",   bus.fifo_wr_en, 1);
        check("t1_dat0",  bus.fifo_wr_data, {1'b0, 32'hA0});
        tick();
        check("t1_wr1",   bus.fifo_wr_en, 1);
        check("t1_dat1",  bus.fifo_wr_data, {1'b0, 32'hA1});
        tick();
        check("t1_wr2",   bus.fifo_wr_en, 1);
        check("t1_dat2",  bus.fifo_wr_data, {1'b1, 32'hA2});
        tick();
        check("t1_end_busy",  bus.busy, 0);
        check("t1_end_wr",    bus.fifo_wr_en, 0);
        check("t1_end_grant", bus.grant_id, 2);
        expect_word("t1_q0", {1'b0, 32'hA0});
        expect_word("t1_q1", {1'b0, 32'hA1});
        expect_word("t1_q2", {1'b1, 32'hA2});

        // All four requesters stream single-beat packets; rotation resumes at 3.
        for (int i = 0; i < N; i++) start(i, 1, 2, 32'((i + 1) << 8));
        settle();
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 1) begin
                check("t2_wr_grant_cycle", bus.fifo_wr_en, 1);
                check("t2_grant", bus.grant_id, rr_order[k / 2]);
            end else begin
                check("t2_wr_idle_cycle", bus.fifo_wr_en, 0);
            end
            tick();
        end
        expect_word("t2_q0", {1'b1, 32'h400});
        expect_word("t2_q1", {1'b1, 32'h100});
        expect_word("t2_q2", {1'b1, 32'h200});
        expect_word("t2_q3", {1'b1, 32'h300});
        expect_word("t2_q4", {1'b1, 32'h401});
        expect_word("t2_q5", {1'b1, 32'h101});
        expect_word("t2_q6", {1'b1, 32'h201});
        expect_word("t2_q7", {1'b1, 32'h301});

        // Requester 3 asks first, requester 1 joins while 3 holds the grant.
        start(3, 2, 1, 32'h3300);
        settle();
        tick();
        start(1, 2, 1, 32'h1100);
        settle();
        check("t3_grant3", bus.grant_id, 3);
        check("t3_ready3", bus.req_ready, 4'b1000);
        tick();
        tick();
        tick();
        check("t3_grant1", bus.grant_id, 1);
        check("t3_busy1",  bus.busy, 1);
        tick();
        tick();
        check("t3_end_busy", bus.busy, 0);
        expect_word("t3_q0", {1'b0, 32'h3300});
        expect_word("t3_q1", {1'b1, 32'h3301});
        expect_word("t3_q2", {1'b0, 32'h1100});
        expect_word("t3_q3", {1'b1, 32'h1101});

        // FIFO full for five cycles in the middle of a 4-beat packet.
        start(2, 4, 1, 32'h4400);
        settle();
        tick();
        check("t4_dat0", bus.fifo_wr_data, {1'b0, 32'h4400});
        tick();
        bus.fifo_wr_full = 1'b1;
        settle();
        for (int k = 0; k < 5; k++) begin
            check("t4_full_ready", bus.req_ready, 0);
            check("t4_full_wr",    bus.fifo_wr_en, 0);
            check("t4_full_grant", bus.grant_id, 2);
            tick();
        end
        bus.fifo_wr_full = 1'b0;
        settle();
        check("t4_resume_wr",    bus.fifo_wr_en, 1);
        check("t4_resume_ready", bus.req_ready, 4'b0100);
        check("t4_resume_dat",   bus.fifo_wr_data, {1'b0, 32'h4401});
        tick();
        tick();
        tick();
        check("t4_end_busy", bus.busy, 0);
        expect_word("t4_q0", {1'b0, 32'h4400});
        expect_word("t4_q1", {1'b0, 32'h4401});
        expect_word("t4_q2", {1'b0, 32'h4402});
        expect_word("t4_q3", {1'b1, 32'h4403});

        // Granted requester 3 stalls for three cycles while 0 and 1 wait.
        start(3, 3, 1, 32'h5500);
        start(0, 1, 1, 32'h6600);
        start(1, 1, 1, 32'h7700);
        settle();
        tick();
        check("t5_grant3", bus.grant_id, 3);
        tick();
        en[3] = 1'b0;
        settle();
        for (int k = 0; k < 3; k++) begin
            check("t5_hold_wr",    bus.fifo_wr_en, 0);
            check("t5_hold_grant", bus.grant_id, 3);
            check("t5_hold_ready", bus.req_ready, 4'b1000);
            tick();
        end
        en[3] = 1'b1;
        settle();
        check("t5_resume_dat", bus.fifo_wr_data, {1'b0, 32'h5501});
        tick();
        tick();
        tick();
        check("t5_grant0", bus.grant_id, 0);
        tick();
        tick();
        check("t5_grant1", bus.grant_id, 1);
        tick();
        check("t5_end_busy", bus.busy, 0);
        expect_word("t5_q0", {1'b0, 32'h5500});
        expect_word("t5_q1", {1'b0, 32'h5501});
        expect_word("t5_q2", {1'b1, 32'h5502});
        expect_word("t5_q3", {1'b1, 32'h6600});
        expect_word("t5_q4", {1'b1, 32'h7700});

        // Reset pulse after two beats of a 4-beat packet from requester 1.
        start(1, 4, 1, 32'h8800);
        settle();
        tick();
        check("t6_grant1", bus.grant_id, 1);
        tick();
        tick();
        check("t6_pre_busy", bus.busy, 1);
        check("t6_pre_wr",   bus.fifo_wr_en, 1);
        reset = 1'b1;
        #1;
        check("t6_rst_busy",  bus.busy, 0);
        check("t6_rst_ready", bus.req_ready, 0);
        check("t6_rst_wr",    bus.fifo_wr_en, 0);
        check("t6_rst_grant", bus.grant_id, 0);
        tick();
        reset = 1'b0;
        start(0, 1, 1, 32'h9900);
        settle();
        check("t6_idle_wr", bus.fifo_wr_en, 0);
        tick();
        check("t6_grant0", bus.grant_id, 0);
        check("t6_dat0",   bus.fifo_wr_data, {1'b1, 32'h9900});
        tick();
        tick();
        check("t6_grant1b", bus.grant_id, 1);
        check("t6_dat1",    bus.fifo_wr_data, {1'b0, 32'h8802});
        tick();
        tick();
        check("t6_end_busy", bus.busy, 0);
        expect_word("t6_q0", {1'b0, 32'h8800});
        expect_word("t6_q1", {1'b0, 32'h8801});
        expect_word("t6_q2", {1'b1, 32'h9900});
        expect_word("t6_q3", {1'b0, 32'h8802});
        expect_word("t6_q4", {1'b1, 32'h8803});
        check("fifo_drained", wq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
